// File: rtl/ad4003_acq_ctrl_pkg.sv
// Shared types and constants for the AD4003 acquisition controller.
package ad4003_acq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCfgWr = 2'd1,
    StCfgRd = 2'd2,
    StAcq   = 2'd3
  } acq_state_e;

  // Register access commands: write to config register, read back config register.
  localparam logic [7:0]  CmdWr   = 8'h14;
  localparam logic [7:0]  CmdRd   = 8'h54;
  // Second byte of a read command is don't-care; keep SDI high.
  localparam logic [7:0]  RdPad   = 8'hFF;
  localparam logic        SdiIdle = 1'b1;
  localparam int unsigned CmdLen  = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ad4003_lane_shifter.sv
// One SDO lane: MSB-first shift register, advanced only while capture is enabled.
module ad4003_lane_shifter #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             adc_spi_clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             sdo,
  output logic [WIDTH-1:0] shift_q
);

  // Shift in one SDO bit per enabled rising edge; reset discards partial frames.
  always_ff @(posedge adc_spi_clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (cap_en) begin
      shift_q <= {shift_q[WIDTH-2:0], sdo};
    end
  end

endmodule

// File: rtl/ad4003_acq_ctrl.sv
// AD4003 front-end controller: register configuration with readback, then free-running
// conversion frames deserialised on all lanes in the SCK source clock domain.
module ad4003_acq_ctrl
  import ad4003_acq_ctrl_pkg::*;
#(
  parameter int unsigned N_CH      = 24,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned CYC_LEN   = 40,
  parameter int unsigned CNV_HI    = 16,
  parameter int unsigned SDO_LAG   = 2,
  parameter logic [7:0]  CFG_DATA  = 8'h02,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                     adc_spi_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cfg_req,
  input  logic [N_CH-1:0]          sdo,
  output logic                     cnv,
  output logic                     sck,
  output logic                     sdi,
  output logic [N_CH*DATA_W-1:0]   adc_data,
  output logic                     data_valid,
  output logic                     cfg_ok,
  output logic                     cfg_err,
  output logic [31:0]              frame_cnt
);

  localparam int unsigned S0      = CNV_HI + 2;
  localparam int unsigned SHIFT_W = max_u(DATA_W, CmdLen);
  localparam int unsigned CNT_W   = $clog2(CYC_LEN);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CntLast       = CNT_W'(CYC_LEN - 1);
  localparam logic [CNT_W-1:0] CntCnvHi      = CNT_W'(CNV_HI);
  localparam logic [CNT_W-1:0] CntSckStartM1 = CNT_W'(S0 - 1);
  localparam logic [CNT_W-1:0] CntSckEndAcq  = CNT_W'(S0 + DATA_W - 1);
  localparam logic [CNT_W-1:0] CntSckEndCfg  = CNT_W'(S0 + CmdLen - 1);
  localparam logic [CNT_W-1:0] CntCapStart   = CNT_W'(S0 + SDO_LAG);
  localparam logic [CNT_W-1:0] CntCapEndAcq  = CNT_W'(S0 + SDO_LAG + DATA_W);
  localparam logic [CNT_W-1:0] CntCapEndCfg  = CNT_W'(S0 + SDO_LAG + CmdLen);
  localparam logic [CNT_W-1:0] CntStrobe     = CNT_W'(S0 + DATA_W + SDO_LAG);

  localparam logic [CmdLen-1:0] WrWord = {CmdWr, CFG_DATA};
  localparam logic [CmdLen-1:0] RdWord = {CmdRd, RdPad};

  // The whole SCK window plus capture lag must finish before the strobe/wrap cycle.
  if (S0 + max_u(DATA_W, CmdLen) + SDO_LAG >= CYC_LEN - 1) begin : g_bad_timing
    $error("ad4003_acq_ctrl: SCK window plus SDO_LAG does not fit in CYC_LEN");
  end

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  acq_state_e               state_q, state_d;
  logic                     cfg_pend_q, cfg_pend_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic                     cfg_ok_q, cfg_ok_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     cnv_q, data_valid_q;
  logic [N_CH*DATA_W-1:0]   adc_data_q, lane_word;
  logic [31:0]              frame_cnt_q;
  logic                     sck_en_q, sdi_q;
  logic                     cnt_wrap, pend_now, cap_en, strobe, rd_match;
  logic [N_CH-1:0]          lane_match;
  logic [CNT_W-1:0]         cap_end, sck_end_m1, bit_sel;
  logic [CmdLen-1:0]        cmd_word, cmd_shifted;
  logic [SHIFT_W-1:0]       lane_sh [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    ad4003_lane_shifter #(
      .WIDTH (SHIFT_W)
    ) u_shift (
      .adc_spi_clk (adc_spi_clk),
      .rst         (rst),
      .cap_en      (cap_en),
      .sdo         (sdo[i]),
      .shift_q     (lane_sh[i])
    );
    // Readback byte is the last 8 bits clocked out of a 16-bit read frame.
    assign lane_match[i] = (lane_sh[i][7:0] == CFG_DATA);
    assign lane_word[i*DATA_W +: DATA_W] = lane_sh[i][DATA_W-1:0];
  end

  assign rd_match = &lane_match;

  // Frame counter, frame-boundary state decisions and capture/strobe timing.
  always_comb begin
    cnt_wrap   = (cnt_q == CntLast);
    cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
    pend_now   = cfg_pend_q | cfg_req;
    state_d    = state_q;
    cfg_pend_d = pend_now;
    retry_d    = retry_q;
    cfg_ok_d   = cfg_ok_q;
    cfg_err_d  = cfg_err_q;
    if (cnt_wrap) begin
      unique case (state_q)
        StIdle: begin
          if (pend_now) begin
            state_d    = StCfgWr;
            cfg_pend_d = 1'b0;
            cfg_ok_d   = 1'b0;
          end else if (start && cfg_ok_q) begin
            state_d = StAcq;
          end
        end
        StCfgWr: state_d = StCfgRd;
        StCfgRd: begin
          if (rd_match) begin
            state_d   = StIdle;
            cfg_ok_d  = 1'b1;
            cfg_err_d = 1'b0;
            retry_d   = '0;
          end else if (32'(retry_q) + 32'd1 < MAX_RETRY) begin
            state_d    = StCfgWr;
            cfg_pend_d = 1'b0;
            cfg_ok_d   = 1'b0;
            retry_d    = retry_q + RETRY_W'(1);
          end else begin
            // Give up; a fresh cfg_req gets the full retry budget again.
            state_d   = StIdle;
            cfg_err_d = 1'b1;
            cfg_ok_d  = 1'b0;
            retry_d   = '0;
          end
        end
        StAcq: begin
          if (pend_now) begin
            state_d    = StCfgWr;
            cfg_pend_d = 1'b0;
            cfg_ok_d   = 1'b0;
          end else if (!start) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    cap_end = (state_q == StAcq) ? CntCapEndAcq : CntCapEndCfg;
    cap_en  = (state_q != StIdle) && (cnt_d >= CntCapStart) && (cnt_d < cap_end);
    strobe  = (state_d == StAcq) && (cnt_d == CntStrobe);
  end

  // FSM, configuration status and registered frame outputs aligned with cnt.
  always_ff @(posedge adc_spi_clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      state_q      <= StIdle;
      cfg_pend_q   <= 1'b1;
      retry_q      <= '0;
      cfg_ok_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
      cnv_q        <= 1'b0;
      data_valid_q <= 1'b0;
      adc_data_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      cfg_pend_q   <= cfg_pend_d;
      retry_q      <= retry_d;
      cfg_ok_q     <= cfg_ok_d;
      cfg_err_q    <= cfg_err_d;
      cnv_q        <= (state_d != StIdle) && (cnt_d < CntCnvHi);
      data_valid_q <= strobe;
      if (strobe) begin
        adc_data_q  <= lane_word;
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
    end
  end

  // SCK enable and SDI command bit for the cycle that follows this falling edge.
  always_comb begin
    sck_end_m1  = (state_q == StAcq) ? CntSckEndAcq : CntSckEndCfg;
    bit_sel     = cnt_q - CntSckStartM1;
    cmd_word    = (state_q == StCfgWr) ? WrWord : RdWord;
    cmd_shifted = cmd_word << bit_sel;
  end

  // Falling-edge registers keep the SCK gate glitch-free and give SDI half a cycle of setup.
  always_ff @(negedge adc_spi_clk or posedge rst) begin
    if (rst) begin
      sck_en_q <= 1'b0;
      sdi_q    <= SdiIdle;
    end else begin
      sck_en_q <= (state_q != StIdle) && (cnt_q >= CntSckStartM1) && (cnt_q < sck_end_m1);
      if ((state_q == StCfgWr || state_q == StCfgRd) &&
          (cnt_q >= CntSckStartM1) && (cnt_q < CntSckEndCfg)) begin
        sdi_q <= cmd_shifted[CmdLen-1];
      end else begin
        sdi_q <= SdiIdle;
      end
    end
  end

  assign sck        = adc_spi_clk & sck_en_q;
  assign sdi        = sdi_q;
  assign cnv        = cnv_q;
  assign data_valid = data_valid_q;
  assign adc_data   = adc_data_q;
  assign cfg_ok     = cfg_ok_q;
  assign cfg_err    = cfg_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
